mig_port_arbiter: RTL

- Shares the single MIG DDR2 user (app_*) interface between the CPU instruction-fetch port (read-only) and the CPU data port (read/write with byte selects).
- Converts 32-bit word requests into 128-bit MIG bursts: lane select on reads, byte masking on writes.
- Sequences the command, write-data and read-return handshakes.
- Sits between openmips and sdram_ddr in the board top.
- Replaces the direct hookup of the data RAM to the app_* signals.

---
 rtl/mig_port_arbiter_pkg.sv | 28 ++
 rtl/mig_port_arbiter_wmask.sv | 23 ++
 rtl/mig_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mig_port_arbiter_pkg.sv
// Shared definitions for the MIG port arbiter: FSM states, grant
// encodings, MIG command codes and the word-to-burst address helper.
package mig_port_arbiter_pkg;

  typedef enum logic [2:0] {
    CALIB   = 3'd0,
    IDLE    = 3'd1,
    WR      = 3'd2,
    RD      = 3'd3,
    RD_WAIT = 3'd4,
    ACK     = 3'd5
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  // Byte address bits [27:4] select the 128-bit burst; MIG counts in
  // 16-bit columns, so one BL8 burst spans 8 column addresses.
  function automatic logic [26:0] mig_addr(input logic [27:4] burst);
    return {burst, 3'b000};
  endfunction

endpackage

// File: rtl/mig_port_arbiter_wmask.sv
// mig_wmask_gen: builds the 128-bit write burst and its byte mask from a
// 32-bit word write.
//   lane  : word lane within the burst (byte address bits [3:2])
//   sel   : byte enables of the word, bit i covers byte i
//   wdata : write word, replicated into all four lanes
//   mask  : 1 = byte not written; only the selected lane can be unmasked
//   data  : replicated write burst
module mig_wmask_gen (
  input  logic [1:0]   lane,
  input  logic [3:0]   sel,
  input  logic [31:0]  wdata,
  output logic [15:0]  mask,
  output logic [127:0] data
);
  import mig_port_arbiter_pkg::*;

  always_comb begin
    mask = '1;
    mask[{lane, 2'b00} +: 4] = ~sel;
    data = {4{wdata}};
  end

endmodule

// File: rtl/mig_port_arbiter.sv
// mig_port_arbiter: shares the MIG DDR2 app_* interface between the CPU
// instruction-fetch port (read-only) and the CPU data port (read/write).
//   clk, rst            : clock, synchronous active-high reset
//   init_calib_complete : MIG calibration done; no grants before it
//   if_*                : fetch port, level request held until if_ack
//   d_*                 : data port, level request held until d_ack
//   app_*               : MIG user interface (one BL8 128-bit burst per access)
//   err                 : sticky read-timeout flag
module mig_port_arbiter #(
  parameter int unsigned RD_TIMEOUT   = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init_calib_complete,
  input  logic         if_req,
  input  logic [31:0]  if_addr,
  output logic         if_ack,
  output logic [31:0]  if_rdata,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [3:0]   d_sel,
  input  logic [31:0]  d_addr,
  input  logic [31:0]  d_wdata,
  output logic         d_ack,
  output logic [31:0]  d_rdata,
  output logic [26:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  input  logic         app_rdy,
  output logic [127:0] app_wdf_data,
  output logic [15:0]  app_wdf_mask,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  input  logic         app_wdf_rdy,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_valid,
  output logic         err
);
  import mig_port_arbiter_pkg::*;

  localparam int unsigned CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);
  // Counter is cleared on RD_WAIT entry; the last waiting cycle is the one
  // where it holds RD_TIMEOUT-1, giving RD_TIMEOUT cycles in RD_WAIT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  state_t            state_q, state_d;
  gnt_t              gnt_q, gnt_d;
  gnt_t              last_gnt_q, last_gnt_d;
  logic [27:2]       addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cmd_done_q, cmd_done_d;
  logic              dat_done_q, dat_done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  gnt_t              win;
  logic [15:0]       gen_mask;
  logic [127:0]      gen_data;

  // Address bits outside the burst/lane fields carry no meaning here.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:28], if_addr[1:0],
                              d_addr[31:28], d_addr[1:0]};

  mig_wmask_gen u_wmask (
    .lane  (addr_q[3:2]),
    .sel   (sel_q),
    .wdata (wdata_q),
    .mask  (gen_mask),
    .data  (gen_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CALIB;
      gnt_q      <= GNT_IF;
      last_gnt_q <= GNT_IF;
      addr_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      cmd_done_q <= 1'b0;
      dat_done_q <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      cmd_done_q <= cmd_done_d;
      dat_done_q <= dat_done_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    cmd_done_d = cmd_done_q;
    dat_done_d = dat_done_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    // Round-robin on a tie: the port not granted last time wins.
    if (if_req && d_req) win = (last_gnt_q == GNT_IF) ? GNT_D : GNT_IF;
    else if (d_req)      win = GNT_D;
    else                 win = GNT_IF;

    case (state_q)
      CALIB: begin
        if (init_calib_complete) state_d = IDLE;
      end

      IDLE: begin
        if (if_req || d_req) begin
          gnt_d      = win;
          last_gnt_d = win;
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
          if (win == GNT_D) begin
            addr_d  = d_addr[27:2];
            sel_d   = d_sel;
            wdata_d = d_wdata;
            state_d = d_we ? WR : RD;
          end else begin
            addr_d  = if_addr[27:2];
            state_d = RD;
          end
        end
      end

      WR: begin
        // Command and write-data handshakes complete independently.
        cmd_done_d = cmd_done_q | app_rdy;
        dat_done_d = dat_done_q | app_wdf_rdy;
        if (cmd_done_d && dat_done_d) state_d = ACK;
      end

      RD: begin
        if (app_rdy) begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (app_rd_data_valid) begin
          rdata_d = app_rd_data[{addr_q[3:2], 5'b00000} +: 32];
          state_d = ACK;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = TIMEOUT_DATA;
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = CALIB;
      end
    endcase
  end

  // Output logic
  always_comb begin
    app_en       = 1'b0;
    app_cmd      = CMD_WR;
    app_wdf_wren = 1'b0;
    app_wdf_mask = '0;
    app_wdf_data = '0;
    if_ack       = 1'b0;
    d_ack        = 1'b0;
    if_rdata     = '0;
    d_rdata      = '0;

    case (state_q)
      WR: begin
        app_en       = ~cmd_done_q;
        app_cmd      = CMD_WR;
        app_wdf_wren = ~dat_done_q;
        if (!dat_done_q) begin
          app_wdf_mask = gen_mask;
          app_wdf_data = gen_data;
        end
      end
      RD: begin
        app_en  = 1'b1;
        app_cmd = CMD_RD;
      end
      ACK: begin
        if (gnt_q == GNT_D) begin
          d_ack   = 1'b1;
          d_rdata = rdata_q;
        end else begin
          if_ack   = 1'b1;
          if_rdata = rdata_q;
        end
      end
      default: ;
    endcase

    app_wdf_end = app_wdf_wren;
    app_addr    = mig_addr(addr_q[27:4]);
    err         = err_q;
  end

endmodule
